game_sequencer: RTL and testbench

Frame-rate game controller that drives the sprite/background display path. It owns the background scroll offset, the object's position and jump physics, and the collision bookkeeping: score, lives and the end-of-game blanking. All position outputs are registered and update once per frame, so the display sees stable values for the whole frame. The display path's collision flag feeds back into this block.

---
 rtl/game_pkg.sv | 18 +
 rtl/game_sequencer_btn_edge.sv | 33 +++
 rtl/game_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_game_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, screen constants and coordinate type
// for the game sequencer slice.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned OBJ_SIZE = 40;

    typedef logic [11:0] coord_t;

endpackage

// File: rtl/game_sequencer_btn_edge.sv
// btn_edge: registered rising-edge detector for a debounced button level.
// The pulse is one cycle wide and appears the cycle after the first high
// sample of the button.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic prev_q;
    logic rise_q;
    logic rise_d;

    // Edge condition: high now, low on the previous sample.
    always_comb begin
        rise_d = btn & ~prev_q;
    end

    // Sample history and register the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= btn;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: frame-rate game controller (FSM, background scroll,
// jump physics, score/lives bookkeeping).
// Optional macro SEQ_HIT_BLINK_EN: blink the object during HIT instead of
// hiding it for the whole HIT period.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned SCROLL_STEP = 2,
    parameter int unsigned OBJ_X       = 100,
    parameter int unsigned GROUND_Y    = 400,
    parameter int unsigned JUMP_V0     = 12,
    parameter int unsigned GRAVITY     = 1,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned HIT_FRAMES  = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start_btn,
    input  logic        jump_btn,
    input  logic        collide,
    output logic [11:0] x_begin,
    output logic [11:0] obj_x_begin,
    output logic [11:0] obj_y_begin,
    output logic        end_show,
    output logic [3:0]  score,
    output logic [1:0]  lives,
    output logic [1:0]  state
);

    localparam coord_t            OBJ_X_C  = coord_t'(OBJ_X);
    localparam coord_t            GROUND_C = coord_t'(GROUND_Y);
    localparam logic signed [7:0] V0_C     = 8'(JUMP_V0);
    localparam logic signed [7:0] GRAV_C   = 8'(GRAVITY);
    localparam logic [1:0]        LIVES_C  = 2'(LIVES);
    localparam logic [7:0]        HIT_C    = 8'(HIT_FRAMES);
    localparam logic [12:0]       STEP_C   = 13'(SCROLL_STEP);
    localparam logic [12:0]       WIDTH_C  = 13'(SCREEN_W);

    state_t            state_q, state_d;
    coord_t            x_q, x_d;
    coord_t            y_q, y_d;
    logic signed [7:0] vel_q, vel_d;
    logic              airborne_q, airborne_d;
    logic              jump_req_q, jump_req_d;
    logic              collide_seen_q, collide_seen_d;
    logic [7:0]        hit_cnt_q, hit_cnt_d;
    logic [3:0]        score_q, score_d;
    logic [1:0]        lives_q, lives_d;
    logic              end_show_q, end_show_d;
`ifdef SEQ_HIT_BLINK_EN
    logic [1:0]        blink_cnt_q, blink_cnt_d;
`endif

    logic              start_rise;
    logic              jump_rise;
    logic              hit_now;
    logic signed [7:0] vel_eff;
    logic              air_eff;
    logic signed [12:0] y_new;
    logic [12:0]       x_sum;

    btn_edge u_start_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (start_btn),
        .rise (start_rise)
    );

    btn_edge u_jump_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (jump_btn),
        .rise (jump_rise)
    );

    // A collide on the tick cycle itself still belongs to the ending frame.
    assign hit_now = collide_seen_q | collide;

    // State and datapath registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            x_q            <= '0;
            y_q            <= GROUND_C;
            vel_q          <= '0;
            airborne_q     <= 1'b0;
            jump_req_q     <= 1'b0;
            collide_seen_q <= 1'b0;
            hit_cnt_q      <= '0;
            score_q        <= '0;
            lives_q        <= LIVES_C;
            end_show_q     <= 1'b1;
`ifdef SEQ_HIT_BLINK_EN
            blink_cnt_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            y_q            <= y_d;
            vel_q          <= vel_d;
            airborne_q     <= airborne_d;
            jump_req_q     <= jump_req_d;
            collide_seen_q <= collide_seen_d;
            hit_cnt_q      <= hit_cnt_d;
            score_q        <= score_d;
            lives_q        <= lives_d;
            end_show_q     <= end_show_d;
`ifdef SEQ_HIT_BLINK_EN
            blink_cnt_q    <= blink_cnt_d;
`endif
        end
    end

    // Next-state logic of the game FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_OVER: if (start_rise) state_d = ST_RUN;
            ST_RUN:  if (frame_tick && hit_now)
                         state_d = (lives_q == 2'd1) ? ST_OVER : ST_HIT;
            ST_HIT:  if (frame_tick && hit_cnt_q == 8'd1) state_d = ST_RUN;
            default: state_d = state_q;
        endcase
    end

    // Per-frame scroll, physics and score/lives bookkeeping.
    always_comb begin
        x_d            = x_q;
        y_d            = y_q;
        vel_d          = vel_q;
        airborne_d     = airborne_q;
        jump_req_d     = jump_req_q;
        collide_seen_d = collide_seen_q;
        hit_cnt_d      = hit_cnt_q;
        score_d        = score_q;
        lives_d        = lives_q;

        // A pending jump launches on the same tick it is consumed.
        vel_eff = jump_req_q ? V0_C : vel_q;
        air_eff = jump_req_q | airborne_q;
        y_new   = $signed({1'b0, y_q}) - 13'(vel_eff);
        x_sum   = {1'b0, x_q} + STEP_C;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                collide_seen_d = 1'b0;
                if (start_rise) begin
                    x_d        = '0;
                    y_d        = GROUND_C;
                    vel_d      = '0;
                    airborne_d = 1'b0;
                    jump_req_d = 1'b0;
                    hit_cnt_d  = '0;
                    score_d    = '0;
                    lives_d    = LIVES_C;
                end
            end
            ST_RUN: begin
                if (frame_tick) begin
                    collide_seen_d = 1'b0;
                    if (hit_now) begin
                        lives_d   = lives_q - 2'd1;
                        hit_cnt_d = HIT_C;
                    end else begin
                        if (x_sum >= WIDTH_C) begin
                            x_d = coord_t'(x_sum - WIDTH_C);
                            if (score_q != 4'hF) score_d = score_q + 4'd1;
                        end else begin
                            x_d = coord_t'(x_sum);
                        end
                        jump_req_d = jump_rise & ~air_eff;
                        if (air_eff) begin
                            if (y_new >= $signed({1'b0, GROUND_C})) begin
                                y_d        = GROUND_C;
                                vel_d      = '0;
                                airborne_d = 1'b0;
                            end else begin
                                y_d        = coord_t'(y_new);
                                vel_d      = vel_eff - GRAV_C;
                                airborne_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    collide_seen_d = collide_seen_q | collide;
                    if (jump_rise && !airborne_q) jump_req_d = 1'b1;
                end
            end
            ST_HIT: begin
                collide_seen_d = 1'b0;
                if (frame_tick) begin
                    if (hit_cnt_q == 8'd1) begin
                        hit_cnt_d  = '0;
                        y_d        = GROUND_C;
                        vel_d      = '0;
                        airborne_d = 1'b0;
                        jump_req_d = 1'b0;
                    end else begin
                        hit_cnt_d = hit_cnt_q - 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered visibility output, derived from the state being entered.
    always_comb begin
        end_show_d = 1'b1;
`ifdef SEQ_HIT_BLINK_EN
        blink_cnt_d = blink_cnt_q;
        if (state_d == ST_RUN) begin
            end_show_d = 1'b0;
        end else if (state_d == ST_HIT) begin
            if (state_q != ST_HIT) begin
                end_show_d  = 1'b1;
                blink_cnt_d = '0;
            end else if (frame_tick) begin
                blink_cnt_d = blink_cnt_q + 2'd1;
                end_show_d  = (blink_cnt_q == 2'd3) ? ~end_show_q : end_show_q;
            end else begin
                end_show_d = end_show_q;
            end
        end
`else
        if (state_d == ST_RUN) end_show_d = 1'b0;
`endif
    end

    assign x_begin     = x_q;
    assign obj_x_begin = OBJ_X_C;
    assign obj_y_begin = y_q;
    assign end_show    = end_show_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign state       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scenarios plus a randomized frame-level run
// against a behavioural model of the game rules.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        start_btn;
    logic        jump_btn;
    logic        collide;
    logic [11:0] x_begin;
    logic [11:0] obj_x_begin;
    logic [11:0] obj_y_begin;
    logic        end_show;
    logic [3:0]  score;
    logic [1:0]  lives;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    game_sequencer #(
        .SCROLL_STEP (2),
        .OBJ_X       (100),
        .GROUND_Y    (400),
        .JUMP_V0     (12),
        .GRAVITY     (1),
        .LIVES       (3),
        .HIT_FRAMES  (30)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .jump_btn    (jump_btn),
        .collide     (collide),
        .x_begin     (x_begin),
        .obj_x_begin (obj_x_begin),
        .obj_y_begin (obj_y_begin),
        .end_show    (end_show),
        .score       (score),
        .lives       (lives),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        cycle();
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        cycle();
        start_btn = 1'b0;
        cycle();
    endtask

    task automatic press_jump();
        jump_btn = 1'b1;
        cycle();
        jump_btn = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    // Height of a jump k ticks after launch, from constant-deceleration
    // kinematics: 400 - (12k - k(k-1)/2), clamped to the ground.
    function automatic int jump_y(input int k);
        int h;
        h = 12 * k - (k * (k - 1)) / 2;
        if (k == 0 || h <= 0) return 400;
        return 400 - h;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (x_begin !== 12'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", x_begin); end
        checks++; if (obj_x_begin !== 12'd100) begin failures++; $display("FAIL reset_objx got=%0d exp=100", obj_x_begin); end
        checks++; if (obj_y_begin !== 12'd400) begin failures++; $display("FAIL reset_y got=%0d exp=400", obj_y_begin); end
        checks++; if (end_show !== 1'b1) begin failures++; $display("FAIL reset_end_show got=%0d exp=1", end_show); end
        checks++; if (score !== 4'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
        checks++; if (lives !== 2'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", lives); end
    endtask

    task automatic test_start();
        tick();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL idle_holds got=%0d exp=0", state); end
        press_start();
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", state); end
        checks++; if (end_show !== 1'b0) begin failures++; $display("FAIL start_end_show got=%0d exp=0", end_show); end
        checks++; if (lives !== 2'd3) begin failures++; $display("FAIL start_lives got=%0d exp=3", lives); end
        checks++; if (score !== 4'd0) begin failures++; $display("FAIL start_score got=%0d exp=0", score); end
        checks++; if (x_begin !== 12'd0) begin failures++; $display("FAIL start_x got=%0d exp=0", x_begin); end
        checks++; if (obj_y_begin !== 12'd400) begin failures++; $display("FAIL start_y got=%0d exp=400", obj_y_begin); end
    endtask

    task automatic test_scroll();
        for (int n = 1; n <= 320; n++) begin
            tick();
            if (n == 1 || n == 319) begin
                checks++;
                if (x_begin !== 12'((2 * n) % 640)) begin
                    failures++; $display("FAIL scroll_x n=%0d got=%0d exp=%0d", n, x_begin, (2 * n) % 640);
                end
            end
        end
        checks++; if (x_begin !== 12'd0) begin failures++; $display("FAIL scroll_wrap_x got=%0d exp=0", x_begin); end
        checks++; if (score !== 4'd1) begin failures++; $display("FAIL scroll_score got=%0d exp=1", score); end
        for (int n = 0; n < 15 * 320; n++) tick();
        checks++; if (score !== 4'd15) begin failures++; $display("FAIL score_sat got=%0d exp=15", score); end
        checks++; if (x_begin !== 12'd0) begin failures++; $display("FAIL scroll_end_x got=%0d exp=0", x_begin); end
    endtask

    task automatic test_jump();
        press_jump();
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (k == 5) press_jump();
            checks++;
            if (obj_y_begin !== 12'(jump_y(k))) begin
                failures++; $display("FAIL jump_y k=%0d got=%0d exp=%0d", k, obj_y_begin, jump_y(k));
            end
        end
        // A fresh edge after landing must launch again.
        press_jump();
        tick();
        checks++; if (obj_y_begin !== 12'd388) begin failures++; $display("FAIL rejump_y got=%0d exp=388", obj_y_begin); end
        for (int k = 2; k <= 25; k++) tick();
        checks++; if (obj_y_begin !== 12'd400) begin failures++; $display("FAIL rejump_land got=%0d exp=400", obj_y_begin); end
    endtask

    task automatic test_hit();
        logic [11:0] x0;
        x0 = x_begin;
        frame_tick = 1'b1;
        collide    = 1'b1;
        cycle();
        frame_tick = 1'b0;
        collide    = 1'b0;
        cycle();
        checks++; if (lives !== 2'd2) begin failures++; $display("FAIL hit_lives got=%0d exp=2", lives); end
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL hit_state got=%0d exp=2", state); end
        checks++; if (end_show !== 1'b1) begin failures++; $display("FAIL hit_end_show got=%0d exp=1", end_show); end
        for (int n = 1; n < 30; n++) begin
            if (n == 10) begin collide = 1'b1; cycle(); collide = 1'b0; end
            tick();
        end
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL hit_29_state got=%0d exp=2", state); end
        tick();
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL hit_exit_state got=%0d exp=1", state); end
        checks++; if (obj_y_begin !== 12'd400) begin failures++; $display("FAIL hit_exit_y got=%0d exp=400", obj_y_begin); end
        checks++; if (x_begin !== x0) begin failures++; $display("FAIL hit_x_frozen got=%0d exp=%0d", x_begin, x0); end
        checks++; if (lives !== 2'd2) begin failures++; $display("FAIL hit_ignore_collide got=%0d exp=2", lives); end
        checks++; if (end_show !== 1'b0) begin failures++; $display("FAIL hit_exit_show got=%0d exp=0", end_show); end
    endtask

    task automatic test_over();
        logic [3:0]  s0;
        logic [11:0] x0;
        // Mid-frame collide pulse counts at the next tick.
        collide = 1'b1; cycle(); collide = 1'b0; cycle();
        tick();
        checks++; if (lives !== 2'd1) begin failures++; $display("FAIL over_lives1 got=%0d exp=1", lives); end
        for (int n = 0; n < 30; n++) tick();
        s0 = score;
        x0 = x_begin;
        collide = 1'b1; cycle(); collide = 1'b0;
        tick();
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL over_state got=%0d exp=3", state); end
        checks++; if (end_show !== 1'b1) begin failures++; $display("FAIL over_end_show got=%0d exp=1", end_show); end
        checks++; if (lives !== 2'd0) begin failures++; $display("FAIL over_lives got=%0d exp=0", lives); end
        tick();
        tick();
        checks++; if (score !== s0) begin failures++; $display("FAIL over_score_held got=%0d exp=%0d", score, s0); end
        checks++; if (x_begin !== x0) begin failures++; $display("FAIL over_x_held got=%0d exp=%0d", x_begin, x0); end
        press_start();
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL restart_state got=%0d exp=1", state); end
        checks++; if (lives !== 2'd3) begin failures++; $display("FAIL restart_lives got=%0d exp=3", lives); end
        checks++; if (score !== 4'd0) begin failures++; $display("FAIL restart_score got=%0d exp=0", score); end
        checks++; if (x_begin !== 12'd0) begin failures++; $display("FAIL restart_x got=%0d exp=0", x_begin); end
    endtask

    task automatic test_rst_midjump();
        press_jump();
        for (int k = 1; k <= 6; k++) tick();
        checks++; if (obj_y_begin !== 12'(jump_y(6))) begin failures++; $display("FAIL rst_pre_y got=%0d exp=%0d", obj_y_begin, jump_y(6)); end
        frame_tick = 1'b1;
        rst        = 1'b1;
        cycle();
        frame_tick = 1'b0;
        rst        = 1'b0;
        checks++; if (obj_y_begin !== 12'd400) begin failures++; $display("FAIL rst_y got=%0d exp=400", obj_y_begin); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (end_show !== 1'b1) begin failures++; $display("FAIL rst_end_show got=%0d exp=1", end_show); end
        checks++; if (x_begin !== 12'd0) begin failures++; $display("FAIL rst_x got=%0d exp=0", x_begin); end
        cycle();
    endtask

    // Randomized frames checked against a frame-level model of the rules.
    task automatic test_random();
        int m_state, m_x, m_score, m_lives, m_y, m_jk, m_hit_left;
        bit m_jreq, m_seen;
        bit ev_start, ev_jump, ev_col, ev_col_tick;
        int gap;
        do_reset();
        m_state = 0; m_x = 0; m_score = 0; m_lives = 3; m_y = 400;
        m_jk = 0; m_jreq = 0; m_seen = 0; m_hit_left = 0;
        for (int f = 0; f < 600; f++) begin
            ev_start    = (f == 0) || ($urandom_range(0, 19) == 0);
            ev_jump     = ($urandom_range(0, 3) == 0);
            ev_col      = ($urandom_range(0, 14) == 0);
            ev_col_tick = ($urandom_range(0, 19) == 0);
            gap         = $urandom_range(0, 3);
            if (ev_start) begin
                press_start();
                if (m_state == 0 || m_state == 3) begin
                    m_state = 1; m_x = 0; m_score = 0; m_lives = 3; m_y = 400;
                    m_jk = 0; m_jreq = 0; m_seen = 0;
                end
            end
            if (ev_jump) begin
                press_jump();
                if (m_state == 1 && m_jk == 0) m_jreq = 1;
            end
            if (ev_col) begin
                collide = 1'b1; cycle(); collide = 1'b0;
                if (m_state == 1) m_seen = 1;
            end
            for (int g = 0; g < gap; g++) cycle();
            if (ev_col_tick && m_state == 1) m_seen = 1;
            collide    = ev_col_tick;
            frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
            collide    = 1'b0;
            if (m_state == 1) begin
                if (m_seen) begin
                    m_seen  = 0;
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_state = 3;
                    else begin m_state = 2; m_hit_left = 30; end
                end else begin
                    m_x = m_x + 2;
                    if (m_x >= 640) begin
                        m_x = m_x - 640;
                        if (m_score < 15) m_score++;
                    end
                    if (m_jreq) begin m_jreq = 0; m_jk = 1; end
                    else if (m_jk > 0) m_jk++;
                    m_y = jump_y(m_jk);
                    if (m_jk > 0 && m_y == 400) m_jk = 0;
                end
            end else if (m_state == 2) begin
                m_hit_left--;
                if (m_hit_left == 0) begin
                    m_state = 1; m_y = 400; m_jk = 0; m_jreq = 0;
                end
            end
            checks++; if (state !== 2'(m_state)) begin failures++; $display("FAIL rand_state f=%0d got=%0d exp=%0d", f, state, m_state); end
            checks++; if (x_begin !== 12'(m_x)) begin failures++; $display("FAIL rand_x f=%0d got=%0d exp=%0d", f, x_begin, m_x); end
            checks++; if (obj_y_begin !== 12'(m_y)) begin failures++; $display("FAIL rand_y f=%0d got=%0d exp=%0d", f, obj_y_begin, m_y); end
            checks++; if (score !== 4'(m_score)) begin failures++; $display("FAIL rand_score f=%0d got=%0d exp=%0d", f, score, m_score); end
            checks++; if (lives !== 2'(m_lives)) begin failures++; $display("FAIL rand_lives f=%0d got=%0d exp=%0d", f, lives, m_lives); end
            checks++; if (end_show !== (m_state != 1)) begin failures++; $display("FAIL rand_end_show f=%0d got=%0d exp=%0d", f, end_show, m_state != 1); end
        end
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        start_btn  = 1'b0;
        jump_btn   = 1'b0;
        collide    = 1'b0;
        test_reset();
        test_start();
        test_scroll();
        test_jump();
        test_hit();
        test_over();
        test_rst_midjump();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
